multi_timer: RTL and testbench

Parametrised multi-channel tick generator for the Breakout game logic, covering game tick, ball step, paddle step and similar rates. Each channel has a run-time programmable period, a per-channel enable and a periodic or one-shot mode. Each channel produces a single-cycle registered pulse. It replaces fixed single-rate timers, so one instance serves every rate-driven block in the game.

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_channel.sv | 103 ++++++++++
 rtl/multi_timer.sv | 49 ++++
 tb/tb_multi_timer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
// One-shot support is compiled in only when MULTI_TIMER_ONESHOT_EN is defined.
package timer_pkg;

    typedef enum logic {
        TMR_PERIODIC = 1'b0,
        TMR_ONESHOT  = 1'b1
    } tmr_mode_e;

    localparam int TMR_CNT_W          = 31;
    localparam int TMR_DEFAULT_PERIOD = 250_000;

    // Channel-select width; a single-channel instance still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// Single timer channel: period register, up-counter and registered pulse/busy.
// Mode and done registers exist only when MULTI_TIMER_ONESHOT_EN is defined.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W          = TMR_CNT_W,
    parameter int DEFAULT_PERIOD = TMR_DEFAULT_PERIOD
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_oneshot,
    output logic             o_pulse,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_count;
    logic             r_pulse;
    logic             r_busy;
    logic             w_tc;

    assign w_tc = (r_count == r_period);

`ifdef MULTI_TIMER_ONESHOT_EN
    tmr_mode_e r_mode;
    logic      r_done;

    // A cfg write takes priority over a coincident terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= CNT_W'(DEFAULT_PERIOD);
            r_count  <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_mode   <= TMR_PERIODIC;
            r_done   <= 1'b0;
        end else if (i_we) begin
            r_period <= i_period;
            r_mode   <= tmr_mode_e'(i_oneshot);
            r_count  <= '0;
            r_done   <= 1'b0;
            r_pulse  <= 1'b0;
            r_busy   <= i_en;
        end else if (!i_en) begin
            r_count  <= '0;
            r_done   <= 1'b0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (r_done) begin
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_tc) begin
            r_count  <= '0;
            r_pulse  <= 1'b1;
            if (r_mode == TMR_ONESHOT) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end else begin
                r_busy <= 1'b1;
            end
        end else begin
            r_count  <= r_count + 1'b1;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b1;
        end
    end
`else
    logic w_unused_oneshot;
    assign w_unused_oneshot = i_oneshot;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_period <= CNT_W'(DEFAULT_PERIOD);
            r_count  <= '0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= i_en;
            if (i_we) begin
                r_period <= i_period;
                r_count  <= '0;
                r_pulse  <= 1'b0;
            end else if (!i_en) begin
                r_count  <= '0;
                r_pulse  <= 1'b0;
            end else if (w_tc) begin
                r_count  <= '0;
                r_pulse  <= 1'b1;
            end else begin
                r_count  <= r_count + 1'b1;
                r_pulse  <= 1'b0;
            end
        end
    end
`endif

    assign o_pulse = r_pulse;
    assign o_busy  = r_busy;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel tick generator: decodes cfg writes and fans out to NUM_CH channels.
// Define MULTI_TIMER_ONESHOT_EN to build the channels with one-shot support.
module multi_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = TMR_CNT_W,
    parameter int DEFAULT_PERIOD = TMR_DEFAULT_PERIOD,
    localparam int CH_W          = ch_idx_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_period,
    input  logic              i_cfg_oneshot,
    output logic [NUM_CH-1:0] o_pulse,
    output logic [NUM_CH-1:0] o_busy
);

    logic              w_in_range;
    logic [NUM_CH-1:0] w_ch_we;

    // Out-of-range addresses are dropped so no channel sees the write.
    assign w_in_range = (int'(i_cfg_ch) < NUM_CH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_ch_we[gi] = i_cfg_we & w_in_range & (i_cfg_ch == CH_W'(gi));

            timer_channel #(
                .CNT_W          (CNT_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_channel (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_en      (i_ch_en[gi]),
                .i_we      (w_ch_we[gi]),
                .i_period  (i_cfg_period),
                .i_oneshot (i_cfg_oneshot),
                .o_pulse   (o_pulse[gi]),
                .o_busy    (o_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (short default period for runtime).
// Expectations for the one-shot case follow MULTI_TIMER_ONESHOT_EN.
module tb_multi_timer;

    localparam int NCH   = 4;
    localparam int CW    = 31;
    localparam int DEFP  = 20;

    logic            clk;
    logic            rst_n;
    logic [NCH-1:0]  ch_en;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic [CW-1:0]   cfg_period;
    logic            cfg_oneshot;
    logic [NCH-1:0]  pulse;
    logic [NCH-1:0]  busy;

    logic [2:0]      ch_en2;
    logic            cfg_we2;
    logic [1:0]      cfg_ch2;
    logic [2:0]      pulse2;
    logic [2:0]      busy2;

    int n_cmp = 0;
    int n_err = 0;

    multi_timer #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ch_en(ch_en), .i_cfg_we(cfg_we),
        .i_cfg_ch(cfg_ch), .i_cfg_period(cfg_period), .i_cfg_oneshot(cfg_oneshot),
        .o_pulse(pulse), .o_busy(busy)
    );

    // Three-channel instance so a 2-bit select can address a missing channel.
    multi_timer #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ch_en(ch_en2), .i_cfg_we(cfg_we2),
        .i_cfg_ch(cfg_ch2), .i_cfg_period(cfg_period), .i_cfg_oneshot(cfg_oneshot),
        .o_pulse(pulse2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int per, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_period  = CW'(per);
        cfg_oneshot = os;
        step();
        cfg_we      = 1'b0;
        cfg_oneshot = 1'b0;
    endtask

    // Runs n cycles; reports index of first pulse on ch (0 if none) and pulse count.
    task automatic run_ch(input int ch, input int n, output int first, output int cnt);
        first = 0;
        cnt   = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (pulse[ch]) begin
                if (first == 0) first = k;
                cnt++;
            end
        end
    endtask

    initial begin
        int first, cnt, last, bok, other;

        rst_n = 1'b0; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_oneshot = 1'b0;
        ch_en2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0;
        repeat (3) step();
        check_eq("reset_pulse", int'(pulse), 0);
        check_eq("reset_busy",  int'(busy), 0);
        rst_n = 1'b1;
        step();

        // Default period on ch0: pulses every DEFP+1 cycles, busy held high.
        ch_en = 4'b0001;
        first = 0; cnt = 0; last = 0; bok = 1;
        for (int k = 1; k <= 3 * (DEFP + 1); k++) begin
            step();
            if (pulse[0]) begin
                if (first == 0) first = k;
                last = k;
                cnt++;
            end
            if (!busy[0]) bok = 0;
        end
        check_eq("t1_first_pulse", first, DEFP + 1);
        check_eq("t1_pulse_count", cnt, 3);
        check_eq("t1_last_pulse",  last, 3 * (DEFP + 1));
        check_eq("t1_busy_held",   bok, 1);

        // ch1 P=3, ch2 P=0, ch0/ch3 disabled.
        ch_en = '0;
        step();
        cfg_write(1, 3, 1'b0);
        cfg_write(2, 0, 1'b0);
        ch_en = 4'b0110;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_eq($sformatf("t2_pulse_c%0d", k), int'(pulse), 4 | ((k % 4 == 0) ? 2 : 0));
        end

        // cfg write coinciding with ch1 terminal count suppresses the pulse.
        repeat (3) step();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = CW'(10);
        step();
        cfg_we = 1'b0;
        check_eq("t4_tc_write_pulse", int'(pulse[1]), 0);
        run_ch(1, 11, first, cnt);
        check_eq("t4_first_after_write", first, 11);
        check_eq("t4_count_after_write", cnt, 1);

        // Reset asserted mid-count drops outputs without waiting for an edge.
        ch_en = '0;
        step();
        cfg_write(0, 3, 1'b0);
        cfg_write(2, 0, 1'b0);
        ch_en = 4'b0101;
        step();
        step();
        check_eq("t5_pulse_pre_reset", int'(pulse), 4);
        check_eq("t5_busy_pre_reset",  int'(busy), 5);
        rst_n = 1'b0;
        #1;
        check_eq("t5_pulse_in_reset", int'(pulse), 0);
        check_eq("t5_busy_in_reset",  int'(busy), 0);
        step();
        step();
        rst_n = 1'b1;
        run_ch(0, DEFP + 1, first, cnt);
        check_eq("t5_first_after_release", first, DEFP + 1);
        check_eq("t5_count_after_release", cnt, 1);

        // ch3 P=5 with one-shot requested.
        ch_en = '0;
        step();
        cfg_write(3, 5, 1'b1);
        ch_en = 4'b1000;
        run_ch(3, 20, first, cnt);
        check_eq("t3_first_pulse", first, 6);
`ifdef MULTI_TIMER_ONESHOT_EN
        check_eq("t3_pulse_count", cnt, 1);
        check_eq("t3_busy_done",   int'(busy[3]), 0);
`else
        check_eq("t3_pulse_count", cnt, 3);
        check_eq("t3_busy_done",   int'(busy[3]), 1);
`endif
        cfg_write(3, 5, 1'b1);
        run_ch(3, 10, first, cnt);
        check_eq("t3_rearm_first", first, 6);
        check_eq("t3_rearm_count", cnt, 1);
`ifdef MULTI_TIMER_ONESHOT_EN
        check_eq("t3_rearm_busy", int'(busy[3]), 0);
`else
        check_eq("t3_rearm_busy", int'(busy[3]), 1);
`endif

        // Out-of-range write on the 3-channel instance leaves ch0 phase intact.
        ch_en = '0;
        ch_en2 = 3'b001;
        first = 0; cnt = 0; other = 0;
        for (int k = 1; k <= 2 * (DEFP + 1) - 1; k++) begin
            cfg_we2    = (k == 5);
            cfg_ch2    = 2'd3;
            cfg_period = CW'(2);
            step();
            if (pulse2[0]) begin
                if (first == 0) first = k;
                cnt++;
            end
            if (pulse2[2:1] != 2'b00) other = 1;
        end
        cfg_we2 = 1'b0;
        check_eq("t6_first_pulse", first, DEFP + 1);
        check_eq("t6_pulse_count", cnt, 1);
        check_eq("t6_other_ch",    other, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
